// File: rtl/dsm_modulator.sv
// dsm_modulator: first-order delta-sigma (pulse-density) modulator.
// - Deglitches a switch-derived 32-bit target before applying it.
// - Emits a 1-bit stream whose mean density is target_q / 2^32.
// - Counts ones over windows of 2^WIN_BITS enabled cycles for the display.
// Optional feature macro: DSM_DITHER_EN (LFSR carry-in dither to break idle tones).
module dsm_modulator #(
    parameter int SETTLE_CYCLES = 1000,
    parameter int WIN_BITS      = 16
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                enable,
    input  logic [31:0]         target,
    output logic                out,
    output logic [31:0]         target_q,
    output logic                target_upd,
    output logic                settling,
    output logic [WIN_BITS:0]   ones_count,
    output logic                meas_valid
);

    typedef enum logic {RUN, SETTLE} state_t;

    state_t              state;
    logic [31:0]         cand;
    logic [31:0]         settle_cnt;
    logic [31:0]         acc;
    logic [WIN_BITS-1:0] win_cnt;
    logic [WIN_BITS:0]   ones_acc;
    logic                cin;
    logic [32:0]         sum;

    localparam logic [31:0] SETTLE_LAST = 32'(SETTLE_CYCLES - 1);

`ifdef DSM_DITHER_EN
    logic [15:0] lfsr;
    logic        lfsr_fb;

    // Right-shifting Fibonacci form of taps 16,14,13,11.
    assign lfsr_fb = lfsr[0] ^ lfsr[2] ^ lfsr[3] ^ lfsr[5];
    assign cin     = lfsr[0];

    // Dither source advances only on enabled cycles so a frozen modulator stays frozen.
    always_ff @(posedge clk) begin
        if (rst)
            lfsr <= 16'hACE1;
        else if (enable)
            lfsr <= {lfsr_fb, lfsr[15:1]};
    end
`else
    assign cin = 1'b0;
`endif

    // Carry out of the accumulator is the density bit.
    assign sum      = {1'b0, acc} + {1'b0, target_q} + {32'd0, cin};
    assign settling = (state == SETTLE);

    // Deglitch FSM: a new target must hold for SETTLE_CYCLES before it is applied.
    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= RUN;
            cand       <= 32'd0;
            settle_cnt <= 32'd0;
            target_q   <= 32'd0;
            target_upd <= 1'b0;
        end else begin
            target_upd <= 1'b0;
            if (target != cand) begin
                // A change always restarts settling, even on the would-be adoption cycle.
                cand       <= target;
                settle_cnt <= 32'd0;
                state      <= SETTLE;
            end else if (state == SETTLE) begin
                if (settle_cnt == SETTLE_LAST) begin
                    // Pulses even if the value equals the one already applied.
                    target_q   <= cand;
                    target_upd <= 1'b1;
                    state      <= RUN;
                end else begin
                    settle_cnt <= settle_cnt + 32'd1;
                end
            end
        end
    end

    // Modulator accumulator; disabled cycles hold the phase and force the output low.
    always_ff @(posedge clk) begin
        if (rst) begin
            acc <= 32'd0;
            out <= 1'b0;
        end else if (enable) begin
            acc <= sum[31:0];
            out <= sum[32];
        end else begin
            out <= 1'b0;
        end
    end

    // Windowed ones counter over enabled cycles; the window is not restarted by target changes.
    always_ff @(posedge clk) begin
        if (rst) begin
            win_cnt    <= '0;
            ones_acc   <= '0;
            ones_count <= '0;
            meas_valid <= 1'b0;
        end else begin
            meas_valid <= 1'b0;
            if (enable) begin
                win_cnt <= win_cnt + 1'b1;
                if (win_cnt == '1) begin
                    ones_count <= ones_acc + {{WIN_BITS{1'b0}}, out};
                    ones_acc   <= '0;
                    meas_valid <= 1'b1;
                end else begin
                    ones_acc <= ones_acc + {{WIN_BITS{1'b0}}, out};
                end
            end
        end
    end

endmodule

// File: tb/tb_dsm_modulator.sv
// Directed bench for dsm_modulator with SETTLE_CYCLES=4, WIN_BITS=8.
// Edge numbers in comments (E<n>) count rising edges after reset release.
module tb_dsm_modulator;

    localparam int SC = 4;
    localparam int WB = 8;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          enable = 1'b0;
    logic [31:0]   target = 32'd0;
    logic          out;
    logic [31:0]   target_q;
    logic          target_upd;
    logic          settling;
    logic [WB:0]   ones_count;
    logic          meas_valid;

    int n_run  = 0;
    int n_fail = 0;

    always #5 clk = ~clk;

    dsm_modulator #(.SETTLE_CYCLES(SC), .WIN_BITS(WB)) dut (
        .clk        (clk),
        .rst        (rst),
        .enable     (enable),
        .target     (target),
        .out        (out),
        .target_q   (target_q),
        .target_upd (target_upd),
        .settling   (settling),
        .ones_count (ones_count),
        .meas_valid (meas_valid)
    );

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_run++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic do_reset();
        rst    = 1'b1;
        enable = 1'b0;
        target = 32'd0;
        tick(2);
        rst = 1'b0;
    endtask

    task automatic chk_reset_vals(input string tag);
        chk({tag, "_out"},        64'(out),        64'(0));
        chk({tag, "_target_q"},   64'(target_q),   64'(0));
        chk({tag, "_target_upd"}, 64'(target_upd), 64'(0));
        chk({tag, "_settling"},   64'(settling),   64'(0));
        chk({tag, "_ones_count"}, 64'(ones_count), 64'(0));
        chk({tag, "_meas_valid"}, 64'(meas_valid), 64'(0));
    endtask

    initial begin
        int upd_n;
        int ones_n;
        int mv_n;
        logic [3:0] pat;

        // ---- reset state
        do_reset();
        chk_reset_vals("rst0");

        // ---- 1: half density, settling and first windows
        target = 32'h8000_0000;
        enable = 1'b1;
        tick(1);                                   // E1
        chk("t1_settling_E1", 64'(settling), 64'(1));
        chk("t1_tq_E1", 64'(target_q), 64'(0));
        tick(3);                                   // E4
        chk("t1_settling_E4", 64'(settling), 64'(1));
        chk("t1_upd_E4", 64'(target_upd), 64'(0));
        tick(1);                                   // E5 adopt
        chk("t1_settling_E5", 64'(settling), 64'(0));
        chk("t1_upd_E5", 64'(target_upd), 64'(1));
        chk("t1_tq_E5", 64'(target_q), 64'(32'h8000_0000));
        chk("t1_out_E5", 64'(out), 64'(0));
        tick(1);                                   // E6
        chk("t1_upd_E6", 64'(target_upd), 64'(0));
        chk("t1_out_E6", 64'(out), 64'(0));
        tick(1);                                   // E7
        chk("t1_out_E7", 64'(out), 64'(1));
        tick(1);                                   // E8
        chk("t1_out_E8", 64'(out), 64'(0));
        tick(247);                                 // E255
        chk("t1_mv_E255", 64'(meas_valid), 64'(0));
        tick(1);                                   // E256: ones after E7..E255 odd = 125
        chk("t1_mv_E256", 64'(meas_valid), 64'(1));
        chk("t1_cnt_win1", 64'(ones_count), 64'(125));
        tick(1);                                   // E257
        chk("t1_mv_E257", 64'(meas_valid), 64'(0));
        tick(255);                                 // E512
        chk("t1_mv_E512", 64'(meas_valid), 64'(1));
        chk("t1_cnt_win2", 64'(ones_count), 64'(128));

        // ---- 2: quarter density, change mid-window
        target = 32'h4000_0000;
        tick(5);                                   // E517 adopt
        chk("t2_tq_E517", 64'(target_q), 64'(32'h4000_0000));
        chk("t2_upd_E517", 64'(target_upd), 64'(1));
        for (int i = 0; i < 4; i++) begin          // E518..E521
            tick(1);
            pat[3-i] = out;
        end
        chk("t2_out_pattern", 64'(pat), 64'(4'b0001));
        tick(247);                                 // E768: 3 (old rate) + 62 (new rate)
        chk("t2_mv_E768", 64'(meas_valid), 64'(1));
        chk("t2_cnt_win3", 64'(ones_count), 64'(65));
        tick(256);                                 // E1024
        chk("t2_mv_E1024", 64'(meas_valid), 64'(1));
        chk("t2_cnt_win4", 64'(ones_count), 64'(64));

        // ---- 3: bouncing target (modulator disabled, FSM still runs)
        do_reset();
        target = 32'h1111_1111;
        tick(5);                                   // E5 adopt A
        chk("t3_tq_A", 64'(target_q), 64'(32'h1111_1111));
        upd_n = 0;
        target = 32'h2222_2222;
        repeat (2) begin tick(1); upd_n += int'(target_upd); end
        target = 32'h1111_1111;
        repeat (2) begin tick(1); upd_n += int'(target_upd); end
        target = 32'h2222_2222;
        repeat (4) begin tick(1); upd_n += int'(target_upd); end   // E13
        chk("t3_tq_hold_A", 64'(target_q), 64'(32'h1111_1111));
        chk("t3_settling_E13", 64'(settling), 64'(1));
        tick(1);                                   // E14 adopt B
        upd_n += int'(target_upd);
        chk("t3_tq_B", 64'(target_q), 64'(32'h2222_2222));
        chk("t3_upd_count", 64'(upd_n), 64'(1));
        // change lands on the adoption cycle: change wins
        target = 32'h3333_3333;
        tick(4);                                   // E18, settle_cnt = 3
        target = 32'h4444_4444;
        tick(1);                                   // E19
        chk("t3_collide_tq", 64'(target_q), 64'(32'h2222_2222));
        chk("t3_collide_upd", 64'(target_upd), 64'(0));
        chk("t3_collide_settling", 64'(settling), 64'(1));
        tick(4);                                   // E23
        chk("t3_tq_D", 64'(target_q), 64'(32'h4444_4444));
        chk("t3_upd_D", 64'(target_upd), 64'(1));
        // brief excursion then back to the applied value: still pulses
        target = 32'h5555_5555;
        tick(1);                                   // E24
        target = 32'h4444_4444;
        tick(4);                                   // E28
        chk("t3_readopt_upd_E28", 64'(target_upd), 64'(0));
        tick(1);                                   // E29
        chk("t3_readopt_upd", 64'(target_upd), 64'(1));
        chk("t3_readopt_tq", 64'(target_q), 64'(32'h4444_4444));
        chk("t3_out_disabled", 64'(out), 64'(0));

        // ---- 4: extremes
        do_reset();
        target = 32'hFFFF_FFFF;
        enable = 1'b1;
        tick(5);                                   // E5
        chk("t4_tq_max", 64'(target_q), 64'(32'hFFFF_FFFF));
        tick(1);                                   // E6: first cycle from acc=0
        chk("t4_out_E6", 64'(out), 64'(0));
        tick(1);                                   // E7
        chk("t4_out_E7", 64'(out), 64'(1));
        tick(249);                                 // E256: ones after E7..E255 = 249
        chk("t4_cnt_win1", 64'(ones_count), 64'(249));
        tick(256);                                 // E512
        chk("t4_cnt_full", 64'(ones_count), 64'(256));
        target = 32'd0;
        tick(5);                                   // E517
        chk("t4_tq_zero", 64'(target_q), 64'(0));
        tick(251);                                 // E768: six ones before zero took effect
        chk("t4_cnt_win3", 64'(ones_count), 64'(6));
        ones_n = 0;
        repeat (256) begin tick(1); ones_n += int'(out); end     // E1024
        chk("t4_zero_out_ones", 64'(ones_n), 64'(0));
        chk("t4_mv_E1024", 64'(meas_valid), 64'(1));
        chk("t4_cnt_zero", 64'(ones_count), 64'(0));

        // ---- 5: enable low for 100 cycles mid-window
        do_reset();
        target = 32'h8000_0000;
        enable = 1'b1;
        tick(128);
        enable = 1'b0;
        ones_n = 0;
        mv_n   = 0;
        repeat (100) begin
            tick(1);
            ones_n += int'(out);
            mv_n   += int'(meas_valid);
        end
        chk("t5_out_while_off", 64'(ones_n), 64'(0));
        chk("t5_mv_while_off", 64'(mv_n), 64'(0));
        enable = 1'b1;
        tick(1);                                   // enabled edge 129
        chk("t5_out_resume", 64'(out), 64'(1));
        tick(126);                                 // enabled edge 255
        chk("t5_mv_early", 64'(meas_valid), 64'(0));
        tick(1);                                   // enabled edge 256
        chk("t5_mv_late", 64'(meas_valid), 64'(1));
        chk("t5_cnt", 64'(ones_count), 64'(125));
        tick(1);                                   // enabled edge 257, out=1
        chk("t5_out_before_force", 64'(out), 64'(1));
        enable = 1'b0;
        tick(1);
        chk("t5_out_forced", 64'(out), 64'(0));

        // ---- 6: reset mid-SETTLE and mid-window
        enable = 1'b1;
        target = 32'h1234_5678;
        tick(2);
        chk("t6_settling_pre", 64'(settling), 64'(1));
        rst = 1'b1;
        tick(1);
        chk_reset_vals("t6");
        rst = 1'b0;

        $display("[TB] %0d tests run, %0d failed", n_run, n_fail);
        $finish;
    end

endmodule
